// File: rtl/vga_timing_pkg.sv
// Timing constants and field widths shared by the text-mode scanout core.
// Default geometry is 640x480 visible inside an 800x525 total raster.
package vga_timing_pkg;

   localparam int unsigned H_TOTAL      = 800;
   localparam int unsigned V_TOTAL      = 525;
   localparam int unsigned H_VISIBLE    = 640;
   localparam int unsigned V_VISIBLE    = 480;
   localparam int unsigned H_SYNC_START = 656;
   localparam int unsigned H_SYNC_END   = 752;
   localparam int unsigned V_SYNC_START = 490;
   localparam int unsigned V_SYNC_END   = 492;

   localparam int unsigned GLYPH_W = 8;
   localparam int unsigned GLYPH_H = 8;

   localparam int unsigned X_W   = 10;
   localparam int unsigned Y_W   = 10;
   localparam int unsigned IDX_W = 19;

endpackage : vga_timing_pkg

// File: rtl/vga_text_scanout_wrap_counter.sv
// Enabled up-counter that returns to zero after reaching MAX; wrap flags the
// terminal count so the caller can chain a second counter off it.
module wrap_counter #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned MAX   = 799
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   assign wrap = (count == WIDTH'(MAX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule : wrap_counter

// File: rtl/vga_text_scanout.sv
// Raster timing plus glyph-row serialiser: walks the frame, asks for a new
// glyph row byte at each cell boundary and shifts it out MSB-first.
module vga_text_scanout
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL      = vga_timing_pkg::H_TOTAL,
   parameter int unsigned V_TOTAL      = vga_timing_pkg::V_TOTAL,
   parameter int unsigned H_VISIBLE    = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned V_VISIBLE    = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned H_SYNC_START = vga_timing_pkg::H_SYNC_START,
   parameter int unsigned H_SYNC_END   = vga_timing_pkg::H_SYNC_END,
   parameter int unsigned V_SYNC_START = vga_timing_pkg::V_SYNC_START,
   parameter int unsigned V_SYNC_END   = vga_timing_pkg::V_SYNC_END
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       glyph_row_in,
   output logic [X_W-1:0]   pixel_x,
   output logic [Y_W-1:0]   pixel_y,
   output logic [IDX_W-1:0] pixel_index,
   output logic             visible,
   output logic             load_req,
   output logic             line_end,
   output logic             frame_end,
   output logic             pixel_out,
   output logic             hsync,
   output logic             vsync
);

   logic       last_line;
   logic [7:0] glyph_sr;

   wrap_counter #(
      .WIDTH (X_W),
      .MAX   (H_TOTAL - 1)
   ) u_h_count (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .count (pixel_x),
      .wrap  (line_end)
   );

   wrap_counter #(
      .WIDTH (Y_W),
      .MAX   (V_TOTAL - 1)
   ) u_v_count (
      .clk   (clk),
      .reset (reset),
      .en    (line_end),
      .count (pixel_y),
      .wrap  (last_line)
   );

   assign frame_end = line_end && last_line;
   assign visible   = (pixel_x < X_W'(H_VISIBLE)) && (pixel_y < Y_W'(V_VISIBLE));

   // line_end term primes the first cell of the next line during the last blanking clock
   assign load_req  = (visible && (pixel_x[2:0] == 3'(GLYPH_W - 1))) || line_end;

   assign hsync = !((pixel_x >= X_W'(H_SYNC_START)) && (pixel_x < X_W'(H_SYNC_END)));
   assign vsync = !((pixel_y >= Y_W'(V_SYNC_START)) && (pixel_y < Y_W'(V_SYNC_END)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_index <= '0;
      end else if (frame_end) begin
         pixel_index <= '0;
      end else if (visible) begin
         pixel_index <= pixel_index + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         glyph_sr <= '0;
      end else if (load_req) begin
         glyph_sr <= glyph_row_in;
      end else if (visible) begin
         glyph_sr <= {glyph_sr[6:0], 1'b0};
      end
   end

   assign pixel_out = glyph_sr[7];

endmodule : vga_text_scanout

// File: tb/tb_vga_text_scanout.sv
// Bench for vga_text_scanout: full-size and reduced-geometry instances checked
// every cycle against a raster-position model, plus fixed-point expectations.
module tb_vga_text_scanout;

   logic       clk;
   logic       rst;
   logic [7:0] glyph;

   logic [9:0]  px [2];
   logic [9:0]  py [2];
   logic [18:0] pi [2];
   logic        vis [2];
   logic        ld [2];
   logic        le [2];
   logic        fe [2];
   logic        po [2];
   logic        hs [2];
   logic        vs [2];

   int p_ht [2] = '{800, 40};
   int p_vt [2] = '{525, 12};
   int p_hv [2] = '{640, 24};
   int p_vv [2] = '{480, 8};
   int p_hs [2] = '{656, 28};
   int p_he [2] = '{752, 32};
   int p_vs [2] = '{490, 9};
   int p_ve [2] = '{492, 10};

   int tests = 0;
   int fails = 0;
   int k     = 0;

   vga_text_scanout u_full (
      .clk(clk), .reset(rst), .glyph_row_in(glyph),
      .pixel_x(px[0]), .pixel_y(py[0]), .pixel_index(pi[0]), .visible(vis[0]),
      .load_req(ld[0]), .line_end(le[0]), .frame_end(fe[0]), .pixel_out(po[0]),
      .hsync(hs[0]), .vsync(vs[0])
   );

   vga_text_scanout #(
      .H_TOTAL(40), .V_TOTAL(12), .H_VISIBLE(24), .V_VISIBLE(8),
      .H_SYNC_START(28), .H_SYNC_END(32), .V_SYNC_START(9), .V_SYNC_END(10)
   ) u_small (
      .clk(clk), .reset(rst), .glyph_row_in(glyph),
      .pixel_x(px[1]), .pixel_y(py[1]), .pixel_index(pi[1]), .visible(vis[1]),
      .load_req(ld[1]), .line_end(le[1]), .frame_end(fe[1]), .pixel_out(po[1]),
      .hsync(hs[1]), .vsync(vs[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: raster position since reset, plus the bytes presented on this line
   // and at the last line end; outputs follow from position arithmetic.
   int         mx [2];
   int         my [2];
   logic [7:0] ple [2];
   bit         plv [2];
   logic [7:0] cur_line [2][800];

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            mx[d] = 0; my[d] = 0; plv[d] = 1'b0; ple[d] = 8'h00;
         end else begin
            cur_line[d][mx[d]] = glyph;
            if (mx[d] == p_ht[d] - 1) begin
               ple[d] = glyph; plv[d] = 1'b1;
               mx[d] = 0; my[d] = (my[d] + 1) % p_vt[d];
            end else begin
               mx[d] = mx[d] + 1;
            end
         end
      end
   end

   function automatic logic [45:0] exp_vec(int d);
      int x = mx[d];
      int y = my[d];
      int col = x % 8;
      int src;
      int idx;
      logic v, l, e, f, p, h, s;
      v = (x < p_hv[d]) && (y < p_vv[d]);
      if (y < p_vv[d]) idx = y * p_hv[d] + ((x < p_hv[d]) ? x : p_hv[d]);
      else             idx = p_vv[d] * p_hv[d];
      e = (x == p_ht[d] - 1);
      f = e && (y == p_vt[d] - 1);
      l = (v && col == 7) || e;
      if (v) begin
         src = x - col - 1;
         if (src < 0) p = plv[d] ? ple[d][7 - col] : 1'b0;
         else         p = cur_line[d][src][7 - col];
      end else if (y < p_vv[d]) begin
         p = cur_line[d][p_hv[d] - 1][7];
      end else begin
         p = plv[d] ? ple[d][7] : 1'b0;
      end
      h = !(x >= p_hs[d] && x < p_he[d]);
      s = !(y >= p_vs[d] && y < p_ve[d]);
      return {10'(x), 10'(y), 19'(idx), v, l, e, f, p, h, s};
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [45:0] got;
         logic [45:0] want;
         got  = {px[d], py[d], pi[d], vis[d], ld[d], le[d], fe[d], po[d], hs[d], vs[d]};
         want = exp_vec(d);
         tests++;
         if (got !== want) begin
            fails++;
            $display("FAIL cycle dut%0d k=%0d: got x=%0d y=%0d idx=%0d flags=%b, expected x=%0d y=%0d idx=%0d flags=%b",
                     d, k, got[45:36], got[35:26], got[25:7], got[6:0],
                     want[45:36], want[35:26], want[25:7], want[6:0]);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step_to(input int target, input bit rnd);
      while (k < target) begin
         @(negedge clk);
         k++;
         if (rnd) glyph = 8'($urandom);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_x"}, 32'(px[d]), 0);
         chk({tag, "_y"}, 32'(py[d]), 0);
         chk({tag, "_idx"}, 32'(pi[d]), 0);
         chk({tag, "_pix"}, 32'(po[d]), 0);
         chk({tag, "_flags"}, 32'({vis[d], ld[d], hs[d], vs[d]}), 32'b1011);
      end
   endtask

   logic [7:0] a5 = 8'hA5;
   int         fe_count;

   initial begin
      rst   = 1'b1;
      glyph = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      k   = 0;

      // Constant A5 over the first lines; fixed timing points on the full raster
      glyph = 8'hA5;
      step_to(655, 0); chk("hsync_655", 32'(hs[0]), 1);
      step_to(656, 0); chk("hsync_656", 32'(hs[0]), 0);
      step_to(751, 0); chk("hsync_751", 32'(hs[0]), 0);
      step_to(752, 0); chk("hsync_752", 32'(hs[0]), 1);
      step_to(799, 0);
      chk("line_end_799", 32'(le[0]), 1);
      chk("load_req_799", 32'(ld[0]), 1);
      step_to(800, 0);
      chk("wrap_x", 32'(px[0]), 0);
      chk("wrap_y", 32'(py[0]), 1);
      for (int i = 0; i < 8; i++) begin
         step_to(800 + i, 0);
         chk("a5_cell", 32'(po[0]), 32'(a5[7 - i]));
      end
      chk("load_req_x7", 32'(ld[0]), 1);

      // Blanking hold: last cell byte 80 stays on pixel_out until the line-end load of 0
      step_to(2239, 1);
      glyph = 8'h80;
      step_to(2240, 0);
      glyph = 8'h00;
      chk("blank_hold_640", 32'(po[0]), 1);
      step_to(2398, 0); chk("blank_hold_798", 32'(po[0]), 1);
      step_to(2400, 0);
      chk("blank_next_x", 32'(px[0]), 0);
      chk("blank_next_pix", 32'(po[0]), 0);

      // Asynchronous reset mid-line at (300,3)
      step_to(2700, 1);
      #2 rst = 1'b1;
      #1 chk_reset_vals("async_reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      k   = 0;

      fe_count = 0;
      for (int n = 1; n <= 4800; n++) begin
         step_to(n, 1);
         if (fe[1]) fe_count++;
         if (n == 1)    chk("restart_x", 32'(px[0]), 1);
         if (n == 28)   chk("small_hsync_28", 32'(hs[1]), 0);
         if (n == 32)   chk("small_hsync_32", 32'(hs[1]), 1);
         if (n == 303)  chk("small_idx_last", 32'(pi[1]), 191);
         if (n == 360)  chk("small_vsync_y9", 32'(vs[1]), 0);
         if (n == 400)  chk("small_vsync_y10", 32'(vs[1]), 1);
         if (n == 479)  chk("small_frame_end", 32'(fe[1]), 1);
         if (n == 480)  chk("small_idx_clear", 32'(pi[1]), 0);
         if (n == 1440) chk("full_idx_blank", 32'(pi[0]), 1280);
      end
      chk("small_frame_count", 32'(fe_count), 10);

      step_to(10800, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_vga_text_scanout
